dram_port_arbiter: RTL and testbench

//  Shares the single DRAM controller command port between the instruction-refill port (I)
//  and the data-cache miss port (D) of the CPU on the Nexys4 DDR top.
//  One transaction is outstanding at a time. D has fixed priority, and an aging counter

---
 rtl/dram_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_dram_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM controller command port between the
// instruction-refill port (I) and the data-cache miss port (D).
// One transaction outstanding at a time; D has fixed priority and an aging
// counter forces an I win after STARVE_MAX consecutive D wins while I waits.
// Optional performance counters are built when DRAM_ARB_PERF_EN is defined.
module dram_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic            cmd_we,
    output logic [AW-1:0]   cmd_addr,
    output logic [DW-1:0]   cmd_wdata,
    output logic [DW/8-1:0] cmd_wstrb,
    input  logic            resp_valid,
    input  logic [DW-1:0]   resp_rdata,
    output logic            busy,
    output logic [31:0]     perf_i_cnt,
    output logic [31:0]     perf_d_cnt,
    output logic [31:0]     perf_wait
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [3:0] AGE_MAX = 4'(STARVE_MAX);

    logic [1:0]      r_state;
    logic            r_owner_i;
    logic [3:0]      r_age;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW/8-1:0] r_wstrb;
    logic [DW-1:0]   r_i_rdata;
    logic [DW-1:0]   r_d_rdata;

    logic w_any_req;
    logic w_pick_i;
    logic w_accept;
    logic w_resp;

    assign w_any_req = i_req | d_req;
    assign w_pick_i  = (i_req && (r_age == AGE_MAX)) || !d_req;
    assign w_accept  = (r_state == S_ISSUE) && cmd_ready;
    assign w_resp    = (r_state == S_WAIT) && resp_valid;

    // Arbitration FSM: pick a winner in IDLE, latch its payload, track aging
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_owner_i <= 1'b0;
            r_age     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= S_ISSUE;
                        r_owner_i <= w_pick_i;
                        if (w_pick_i) begin
                            r_we    <= 1'b0;
                            r_addr  <= i_addr;
                            r_wdata <= '0;
                            r_wstrb <= '0;
                            r_age   <= '0;
                        end else begin
                            r_we    <= d_we;
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                            r_wstrb <= d_wstrb;
                            if (i_req && (r_age != AGE_MAX))
                                r_age <= r_age + 4'd1;
                        end
                    end
                end
                S_ISSUE: if (cmd_ready)  r_state <= S_WAIT;
                S_WAIT:  if (resp_valid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Hold the last read data delivered to each port
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_resp) begin
            if (r_owner_i) r_i_rdata <= resp_rdata;
            else           r_d_rdata <= resp_rdata;
        end
    end

    assign cmd_valid = (r_state == S_ISSUE);
    assign cmd_we    = r_we;
    assign cmd_addr  = r_addr;
    assign cmd_wdata = r_wdata;
    assign cmd_wstrb = r_wstrb;
    assign busy      = (r_state != S_IDLE);

    assign i_gnt    = w_accept && r_owner_i;
    assign d_gnt    = w_accept && !r_owner_i;
    assign i_rvalid = w_resp && r_owner_i;
    assign d_rvalid = w_resp && !r_owner_i;
    // Response data passes straight through in its arrival cycle
    assign i_rdata  = (w_resp && r_owner_i)  ? resp_rdata : r_i_rdata;
    assign d_rdata  = (w_resp && !r_owner_i) ? resp_rdata : r_d_rdata;

`ifdef DRAM_ARB_PERF_EN
    logic [31:0] r_perf_i;
    logic [31:0] r_perf_d;
    logic [31:0] r_perf_wait;

    // Grant and contention counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_i    <= '0;
            r_perf_d    <= '0;
            r_perf_wait <= '0;
        end else begin
            if (i_gnt) r_perf_i <= r_perf_i + 32'd1;
            if (d_gnt) r_perf_d <= r_perf_d + 32'd1;
            if (w_any_req && (r_state != S_IDLE))
                r_perf_wait <= r_perf_wait + 32'd1;
        end
    end

    assign perf_i_cnt = r_perf_i;
    assign perf_d_cnt = r_perf_d;
    assign perf_wait  = r_perf_wait;
`else
    assign perf_i_cnt = 32'h0;
    assign perf_d_cnt = 32'h0;
    assign perf_wait  = 32'h0;
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Testbench for dram_port_arbiter: random requesters and DRAM model, with a
// transaction-level reference model feeding scoreboard queues.
module tb_dram_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b0;
    logic            i_req = 1'b0;
    logic [AW-1:0]   i_addr = '0;
    logic            i_gnt, i_rvalid;
    logic [DW-1:0]   i_rdata;
    logic            d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0]   d_addr = '0;
    logic [DW-1:0]   d_wdata = '0;
    logic [SW-1:0]   d_wstrb = '0;
    logic            d_gnt, d_rvalid;
    logic [DW-1:0]   d_rdata;
    logic            cmd_valid, cmd_we;
    logic            cmd_ready = 1'b0;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [SW-1:0]   cmd_wstrb;
    logic            resp_valid = 1'b0;
    logic [DW-1:0]   resp_rdata = '0;
    logic            busy;
    logic [31:0]     perf_i_cnt, perf_d_cnt, perf_wait;

    dram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .busy(busy), .perf_i_cnt(perf_i_cnt), .perf_d_cnt(perf_d_cnt), .perf_wait(perf_wait)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // stimulus controls
    bit auto_i = 0, auto_d = 0, hold_i = 0, hold_d = 0;
    bit bp_mode = 0, spur_en = 0, force_en = 0;
    int pi = 0, pd = 0, p_rdy = 100, lat_fixed = 0;
    logic [31:0] force_data = '0;
    bit man_i_go = 0, man_d_go = 0;
    logic [31:0] man_i_addr = '0, man_d_addr = '0, man_d_wdata = '0;
    logic man_d_we = 0;
    logic [3:0] man_d_wstrb = '0;
    int rst_cnt = 1;
    bit outst = 0;
    int lat_cnt = 0, post_spur = 0, bp_cnt = 0;

    // values seen by the monitor in the previous cycle
    bit s_i_gnt = 0, s_d_gnt = 0, s_acc = 0, s_cv = 0;

    // reference model
    typedef struct {
        bit          own_i;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;
    cmd_t        exp_cmd_q[$];
    logic [31:0] exp_rsp_q[$];
    int          m_phase = 0;   // 0 free, 1 command offered, 2 awaiting response
    bit          m_own_i = 0;
    int          m_age = 0;
    logic [31:0] m_last_i = '0, m_last_d = '0;
    logic [31:0] m_pi = '0, m_pd = '0, m_pw = '0;

    // directed-test bookkeeping
    bit   glog[$];
    int   n_irv = 0, n_drv = 0, n_igt = 0, n_dgt = 0;
    int   cur_len = 0, last_len = 0;
    logic last_i_we = 0, last_d_we = 0;
    logic [3:0]  last_i_wstrb = '0, last_d_wstrb = '0;
    logic [31:0] last_d_wdata = '0;

    // Driver: requesters, DRAM controller model and reset, updated after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_cnt > 0) begin
                rst = 1'b0; rst_cnt--;
                i_req = 1'b0; d_req = 1'b0;
                cmd_ready = 1'b0; resp_valid = 1'b0;
                outst = 0; bp_cnt = 0; post_spur = 2;
                continue;
            end
            rst = 1'b1;
            if (i_req && s_i_gnt) begin
                if (auto_i && (hold_i || $urandom_range(0, 99) < pi))
                    i_addr = $urandom & 32'hFFFF_FFFC;
                else
                    i_req = 1'b0;
            end else if (!i_req) begin
                if (man_i_go) begin
                    i_req = 1'b1; i_addr = man_i_addr; man_i_go = 0;
                end else if (auto_i && (hold_i || $urandom_range(0, 99) < pi)) begin
                    i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
                end
            end
            if (d_req && s_d_gnt) begin
                if (auto_d && (hold_d || $urandom_range(0, 99) < pd)) begin
                    d_we = 1'($urandom); d_addr = $urandom;
                    d_wdata = $urandom; d_wstrb = 4'($urandom);
                end else
                    d_req = 1'b0;
            end else if (!d_req) begin
                if (man_d_go) begin
                    d_req = 1'b1; d_we = man_d_we; d_addr = man_d_addr;
                    d_wdata = man_d_wdata; d_wstrb = man_d_wstrb; man_d_go = 0;
                end else if (auto_d && (hold_d || $urandom_range(0, 99) < pd)) begin
                    d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom;
                    d_wdata = $urandom; d_wstrb = 4'($urandom);
                end
            end
            if (bp_mode) begin
                if (s_acc) bp_cnt = 0;
                else if (s_cv) bp_cnt++;
                cmd_ready = (bp_cnt >= 5);
            end else
                cmd_ready = ($urandom_range(0, 99) < p_rdy);
            resp_valid = 1'b0;
            resp_rdata = $urandom;
            if (s_acc) begin
                outst = 1;
                lat_cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
            end
            if (outst) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    resp_valid = 1'b1;
                    if (force_en) resp_rdata = force_data;
                    exp_rsp_q.push_back(resp_rdata);
                    outst = 0;
                end
            end else if (post_spur > 0) begin
                post_spur--;
                if (post_spur == 0) resp_valid = 1'b1;
            end else if (spur_en && !s_acc && $urandom_range(0, 99) < 4)
                resp_valid = 1'b1;
        end
    end

    // Monitor and reference model, evaluated mid-cycle
    always @(negedge clk) begin
        cmd_t c;
        logic eig, edg, eiv, edv;
        logic [31:0] r;
        s_i_gnt = i_gnt; s_d_gnt = d_gnt; s_cv = cmd_valid; s_acc = cmd_valid && cmd_ready;

        chk("busy", busy, m_phase != 0);
        chk("cmd_valid", cmd_valid, m_phase == 1);
        eig = (m_phase == 1) && cmd_ready && m_own_i;
        edg = (m_phase == 1) && cmd_ready && !m_own_i;
        chk("i_gnt", i_gnt, eig);
        chk("d_gnt", d_gnt, edg);
        if (m_phase == 1) begin
            if (exp_cmd_q.size() != 1) fail_now("cmd_queue");
            else begin
                c = exp_cmd_q[0];
                chk("cmd_we", cmd_we, c.we);
                chk("cmd_addr", cmd_addr, c.addr);
                chk("cmd_wstrb", cmd_wstrb, c.wstrb);
                if (!c.own_i) chk("cmd_wdata", cmd_wdata, c.wdata);
            end
        end
        eiv = (m_phase == 2) && resp_valid && m_own_i;
        edv = (m_phase == 2) && resp_valid && !m_own_i;
        chk("i_rvalid", i_rvalid, eiv);
        chk("d_rvalid", d_rvalid, edv);
        if (eiv || edv) begin
            if (exp_rsp_q.size() == 0) fail_now("rsp_queue_empty");
            else begin
                r = exp_rsp_q.pop_front();
                if (eiv) begin chk("i_rdata", i_rdata, r); m_last_i = r; end
                else     begin chk("d_rdata", d_rdata, r); m_last_d = r; end
            end
        end
        if (!eiv) chk("i_rdata_hold", i_rdata, m_last_i);
        if (!edv) chk("d_rdata_hold", d_rdata, m_last_d);
`ifdef DRAM_ARB_PERF_EN
        chk("perf_i_cnt", perf_i_cnt, m_pi);
        chk("perf_d_cnt", perf_d_cnt, m_pd);
        chk("perf_wait", perf_wait, m_pw);
`else
        chk("perf_i_cnt", perf_i_cnt, 32'h0);
        chk("perf_d_cnt", perf_d_cnt, 32'h0);
        chk("perf_wait", perf_wait, 32'h0);
`endif

        if (i_rvalid) n_irv++;
        if (d_rvalid) n_drv++;
        if (i_gnt) begin n_igt++; last_i_we = cmd_we; last_i_wstrb = cmd_wstrb; end
        if (d_gnt) begin
            n_dgt++; last_d_we = cmd_we; last_d_wstrb = cmd_wstrb; last_d_wdata = cmd_wdata;
        end
        if (cmd_valid) cur_len++;
        if (cmd_valid && cmd_ready) begin
            glog.push_back(i_gnt);
            last_len = cur_len; cur_len = 0;
        end

        if (rst !== 1'b1) begin
            m_phase = 0; m_own_i = 0; m_age = 0;
            m_last_i = '0; m_last_d = '0;
            m_pi = '0; m_pd = '0; m_pw = '0;
            exp_cmd_q.delete(); exp_rsp_q.delete();
            cur_len = 0;
        end else begin
            if (eig) m_pi++;
            if (edg) m_pd++;
            if ((i_req || d_req) && m_phase != 0) m_pw++;
            case (m_phase)
                0: if (i_req || d_req) begin
                    if ((i_req && m_age == STARVE) || !d_req) begin
                        m_own_i = 1; m_age = 0;
                        c.own_i = 1; c.we = 1'b0; c.addr = i_addr; c.wdata = '0; c.wstrb = '0;
                    end else begin
                        m_own_i = 0;
                        if (i_req && m_age < STARVE) m_age++;
                        c.own_i = 0; c.we = d_we; c.addr = d_addr; c.wdata = d_wdata; c.wstrb = d_wstrb;
                    end
                    exp_cmd_q.push_back(c);
                    m_phase = 1;
                end
                1: if (cmd_ready) begin void'(exp_cmd_q.pop_front()); m_phase = 2; end
                2: if (resp_valid) m_phase = 0;
                default: m_phase = 0;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic quiesce();
        auto_i = 0; auto_d = 0; hold_i = 0; hold_d = 0;
        for (int k = 0; k < 300; k++) begin
            step(1);
            if (!i_req && !d_req && m_phase == 0 && !outst && !man_i_go && !man_d_go) return;
        end
        fail_now("quiesce_timeout");
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_d0, n_i0, n_ig0, n_dg0, rv0;
        bit got;
        step(3);
        // reset state of every output
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_we", cmd_we, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_cmd_wdata", cmd_wdata, 0);
        chk("rst_cmd_wstrb", cmd_wstrb, 0);
        chk("rst_gnt", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perf", perf_i_cnt | perf_d_cnt | perf_wait, 0);

        // single D read, response 3 cycles after acceptance
        quiesce();
        glog.delete(); n_d0 = n_drv; n_i0 = n_irv; n_ig0 = n_igt;
        lat_fixed = 3; force_en = 1; force_data = 32'hDEADBEEF; p_rdy = 100;
        man_d_addr = 32'h100; man_d_we = 0; man_d_wdata = $urandom; man_d_wstrb = 4'hF;
        man_d_go = 1;
        quiesce();
        chk("t1_grants", glog.size(), 1);
        if (glog.size() > 0) chk("t1_owner", glog[0], 0);
        chk("t1_d_rvalid_cnt", n_drv - n_d0, 1);
        chk("t1_i_silent", (n_irv - n_i0) + (n_igt - n_ig0), 0);
        chk("t1_d_rdata", d_rdata, 32'hDEADBEEF);
        force_en = 0; lat_fixed = 0;

        // simultaneous requests from idle
        glog.delete();
        man_i_addr = 32'h40;
        man_d_addr = 32'h80; man_d_we = 1; man_d_wdata = $urandom; man_d_wstrb = 4'hF;
        man_i_go = 1; man_d_go = 1;
        quiesce();
        chk("t2_grants", glog.size(), 2);
        if (glog.size() > 1) begin
            chk("t2_first", glog[0], 0);
            chk("t2_second", glog[1], 1);
        end
        chk("t2_i_we", last_i_we, 0);
        chk("t2_i_wstrb", last_i_wstrb, 0);

        // D write with partial strobes
        n_d0 = n_drv;
        man_d_addr = 32'h200; man_d_we = 1; man_d_wdata = 32'h12345678; man_d_wstrb = 4'b0011;
        man_d_go = 1;
        quiesce();
        chk("t5_we", last_d_we, 1);
        chk("t5_wdata", last_d_wdata, 32'h12345678);
        chk("t5_wstrb", last_d_wstrb, 4'b0011);
        chk("t5_completion", n_drv - n_d0, 1);

        // backpressure: ready low for 5 cycles of cmd_valid
        n_dg0 = n_dgt;
        bp_mode = 1;
        man_d_addr = 32'h300; man_d_we = 0; man_d_wdata = $urandom; man_d_wstrb = 4'hF;
        man_d_go = 1;
        quiesce();
        chk("t4_issue_len", last_len, 6);
        chk("t4_single_gnt", n_dgt - n_dg0, 1);
        bp_mode = 0;

        // starvation bound with both requests held
        rst_cnt = 1;
        step(3);
        glog.delete(); p_rdy = 100;
        auto_i = 1; auto_d = 1; hold_i = 1; hold_d = 1;
        for (int k = 0; k < 400 && glog.size() < 10; k++) step(1);
        quiesce();
        if (glog.size() < 10) fail_now("t3_grant_timeout");
        for (int k = 0; k < 10; k++)
            if (k < glog.size()) chk("t3_order", glog[k], (k % 5) == 4);

        // random traffic with backpressure and stray responses
        spur_en = 1; p_rdy = 60; pi = 35; pd = 35;
        auto_i = 1; auto_d = 1;
        step(3000);
        quiesce();

        // reset while awaiting a response
        for (int t = 0; t < 3; t++) begin
            pi = 50; pd = 50; auto_i = 1; auto_d = 1; spur_en = 0;
            got = 0;
            for (int k = 0; k < 300 && !got; k++) begin
                step(1);
                if (m_phase == 2) got = 1;
            end
            if (!got) fail_now("t6_wait_timeout");
            auto_i = 0; auto_d = 0;
            rst_cnt = 1;
            rv0 = n_irv + n_drv;
            step(5);
            chk("t6_busy", busy, 0);
            chk("t6_no_rvalid", (n_irv + n_drv) - rv0, 0);
            chk("t6_perf", perf_i_cnt | perf_d_cnt | perf_wait, 0);
        end
        quiesce();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
